// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the MEM/WB writeback slice.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/writeback_stage_if.sv
// MEM-stage result bundle travelling into the writeback register.
interface writeback_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  import riscv_pkg::*;

  logic                  mem_valid;
  logic                  mem_reg_write;
  logic [REG_ADDR_W-1:0] mem_rd;
  wb_sel_t               mem_wb_sel;
  logic [2:0]            mem_funct3;
  logic [XLEN-1:0]       mem_alu_result;
  logic [XLEN-1:0]       mem_load_word;
  logic [XLEN-1:0]       mem_pc_plus4;
  logic [XLEN-1:0]       mem_imm;

  modport master (
    output mem_valid, mem_reg_write, mem_rd, mem_wb_sel, mem_funct3,
           mem_alu_result, mem_load_word, mem_pc_plus4, mem_imm
  );
  modport slave (
    input  mem_valid, mem_reg_write, mem_rd, mem_wb_sel, mem_funct3,
           mem_alu_result, mem_load_word, mem_pc_plus4, mem_imm
  );
endinterface

// File: rtl/writeback_stage_load_align.sv
// Extracts the addressed byte/halfword from a load word and extends it;
// flags misaligned halfword/word accesses and unknown load types.
module load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data,
  output logic            o_bad
);
  import riscv_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = '0;
    o_bad  = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        o_data = {{(XLEN-16){w_half[15]}}, w_half};
        o_bad  = i_offset[0];
      end
      F3_LHU: begin
        o_data = {{(XLEN-16){1'b0}}, w_half};
        o_bad  = i_offset[0];
      end
      F3_LW: begin
        o_data = i_word;
        o_bad  = (i_offset != 2'd0);
      end
      default: o_bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register: selects and aligns the writeback value, gates
// x0/faulting writes, exports forwarding info and counts retired instructions.
module writeback_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  writeback_stage_if.slave      mem,
  input  logic                  wb_stall,
  input  logic                  wb_flush,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] WriteAdd,
  output logic [XLEN-1:0]       Reg_WriteData,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  load_misalign,
  output logic [CNT_W-1:0]      instret
);
  import riscv_pkg::*;

  logic [XLEN-1:0]       w_load_data;
  logic                  w_load_bad;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_err;
  logic                  w_retire;
  logic                  w_has_rd;

  logic                  r_valid;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_data;
  logic                  r_err;
  logic                  r_committed;
  logic [CNT_W-1:0]      r_instret;

  load_align #(.XLEN(XLEN)) u_load_align (
    .i_word   (mem.mem_load_word),
    .i_offset (mem.mem_alu_result[1:0]),
    .i_funct3 (mem.mem_funct3),
    .o_data   (w_load_data),
    .o_bad    (w_load_bad)
  );

  always_comb begin
    w_sel_data = mem.mem_alu_result;
    case (mem.mem_wb_sel)
      WB_LOAD: w_sel_data = w_load_data;
      WB_PC4:  w_sel_data = mem.mem_pc_plus4;
      WB_IMM:  w_sel_data = mem.mem_imm;
      default: w_sel_data = mem.mem_alu_result;
    endcase
    w_err = (mem.mem_wb_sel == WB_LOAD) && w_load_bad;
  end

  // committed marks an entry whose write/count was already issued while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
      r_err       <= 1'b0;
      r_committed <= 1'b0;
    end else if (wb_flush) begin
      r_valid     <= 1'b0;
      r_committed <= 1'b0;
    end else if (wb_stall) begin
      r_committed <= r_committed | r_valid;
    end else begin
      r_valid     <= mem.mem_valid;
      r_reg_write <= mem.mem_reg_write;
      r_rd        <= mem.mem_rd;
      r_data      <= w_sel_data;
      r_err       <= w_err;
      r_committed <= 1'b0;
    end
  end

  assign w_retire = r_valid & ~r_err & ~r_committed;
  assign w_has_rd = r_reg_write & (r_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign write_en      = w_retire & w_has_rd;
  assign WriteAdd      = r_rd;
  assign Reg_WriteData = r_data;
  assign fwd_valid     = r_valid & ~r_err & w_has_rd;
  assign fwd_rd        = r_rd;
  assign fwd_data      = r_data;
  assign load_misalign = r_valid & r_err & ~r_committed;
  assign instret       = r_instret;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench: expected writes/misalign pulses go into a queue that a
// negedge monitor pops whenever the DUT presents one.
module tb_writeback_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_stall;
  logic        wb_flush;
  logic        write_en;
  logic [4:0]  WriteAdd;
  logic [31:0] Reg_WriteData;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        load_misalign;
  logic [63:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  writeback_stage_if #(.XLEN(32), .REG_ADDR_W(5)) mif ();

  writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mif),
    .wb_stall      (wb_stall),
    .wb_flush      (wb_flush),
    .write_en      (write_en),
    .WriteAdd      (WriteAdd),
    .Reg_WriteData (Reg_WriteData),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .load_misalign (load_misalign),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_w(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.mis = 1'b0; e.rd = rd; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_m();
    exp_t e;
    e.mis = 1'b1; e.rd = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [4:0] rd, input wb_sel_t sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] word,
                       input logic [31:0] pc4, input logic [31:0] imm);
    @(posedge clk); #1;
    mif.mem_valid      = 1'b1;
    mif.mem_reg_write  = 1'b1;
    mif.mem_rd         = rd;
    mif.mem_wb_sel     = sel;
    mif.mem_funct3     = f3;
    mif.mem_alu_result = alu;
    mif.mem_load_word  = word;
    mif.mem_pc_plus4   = pc4;
    mif.mem_imm        = imm;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    mif.mem_valid = 1'b0;
  endtask

  // Monitor: every presented write or misalign pulse must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (write_en === 1'b1 || load_misalign === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {31'd0, load_misalign, 27'd0, WriteAdd}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", {63'd0, load_misalign}, {63'd0, e.mis});
        if (!e.mis) begin
          check("WriteAdd", {59'd0, WriteAdd}, {59'd0, e.rd});
          check("Reg_WriteData", {32'd0, Reg_WriteData}, {32'd0, e.data});
          check("fwd_data", {32'd0, fwd_data}, {32'd0, e.data});
          $display("[TB] write rd=%0d data=0x%08h instret=%0d", WriteAdd, Reg_WriteData, instret);
        end else begin
          $display("[TB] load_misalign pulse instret=%0d", instret);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
    mif.mem_valid = 1'b0; mif.mem_reg_write = 1'b0; mif.mem_rd = '0;
    mif.mem_wb_sel = WB_ALU; mif.mem_funct3 = '0; mif.mem_alu_result = '0;
    mif.mem_load_word = '0; mif.mem_pc_plus4 = '0; mif.mem_imm = '0;
    #12;
    check("rst_write_en", {63'd0, write_en}, 64'd0);
    check("rst_WriteAdd", {59'd0, WriteAdd}, 64'd0);
    check("rst_Reg_WriteData", {32'd0, Reg_WriteData}, 64'd0);
    check("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("rst_load_misalign", {63'd0, load_misalign}, 64'd0);
    check("rst_instret", instret, 64'd0);
    rst_n = 1'b1;

    // Basic writeback sources and load alignment.
    expect_w(5'd5, 32'h0000_1234);
    issue(5'd5, WB_ALU, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 32'h0);
    expect_w(5'd6, 32'h0000_007F);
    issue(5'd6, WB_LOAD, F3_LB, 32'h0000_1001, 32'h80FF_7F01, 32'h0, 32'h0);
    expect_w(5'd8, 32'hFFFF_FF80);
    issue(5'd8, WB_LOAD, F3_LB, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0);
    expect_w(5'd9, 32'h0000_80FF);
    issue(5'd9, WB_LOAD, F3_LHU, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0);
    expect_w(5'd10, 32'hFFFF_80FF);
    issue(5'd10, WB_LOAD, F3_LH, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0);
    issue(5'd0, WB_ALU, 3'b000, 32'h0000_DEAD, 32'h0, 32'h0, 32'h0);
    expect_m();
    issue(5'd11, WB_LOAD, F3_LW, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0);
    expect_w(5'd1, 32'h0000_0104);
    issue(5'd1, WB_PC4, 3'b000, 32'h0, 32'h0, 32'h0000_0104, 32'h0);
    expect_w(5'd2, 32'hABCD_E000);
    issue(5'd2, WB_IMM, 3'b000, 32'h0, 32'h0, 32'h0, 32'hABCD_E000);
    idle();
    repeat (3) @(negedge clk);
    check("instret_after_basic", instret, 64'd8);

    // Stall: one write, forwarding visible the whole time, one retire.
    expect_w(5'd7, 32'h0000_0077);
    issue(5'd7, WB_ALU, 3'b000, 32'h0000_0077, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    mif.mem_valid = 1'b0;
    wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_fwd_valid", {63'd0, fwd_valid}, 64'd1);
      check("stall_fwd_rd", {59'd0, fwd_rd}, 64'd7);
      check("stall_write_en", {63'd0, write_en}, {63'd0, (k == 0)});
      if (k == 3) wb_stall = 1'b0;
    end
    @(negedge clk);
    check("post_stall_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("instret_after_stall", instret, 64'd9);

    // Flush of an entering instruction.
    issue(5'd11, WB_ALU, 3'b000, 32'h0000_0011, 32'h0, 32'h0, 32'h0);
    wb_flush = 1'b1;
    @(posedge clk); #1;
    wb_flush = 1'b0;
    mif.mem_valid = 1'b0;
    @(negedge clk);
    check("flush_write_en", {63'd0, write_en}, 64'd0);
    check("flush_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("instret_after_flush", instret, 64'd9);

    // Flush and stall together on a resident entry: flush wins.
    expect_w(5'd13, 32'h0000_0013);
    issue(5'd13, WB_ALU, 3'b000, 32'h0000_0013, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    mif.mem_valid = 1'b0;
    wb_flush = 1'b1;
    wb_stall = 1'b1;
    @(posedge clk); #1;
    wb_flush = 1'b0;
    wb_stall = 1'b0;
    @(negedge clk);
    check("flushstall_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("flushstall_write_en", {63'd0, write_en}, 64'd0);
    check("instret_after_flushstall", instret, 64'd10);

    // Asynchronous reset while a write is being presented.
    issue(5'd14, WB_ALU, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #2;
    mif.mem_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_write_en", {63'd0, write_en}, 64'd0);
    check("async_rst_WriteAdd", {59'd0, WriteAdd}, 64'd0);
    check("async_rst_Reg_WriteData", {32'd0, Reg_WriteData}, 64'd0);
    check("async_rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("async_rst_instret", instret, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    expect_w(5'd3, 32'h0000_CAFE);
    issue(5'd3, WB_ALU, 3'b000, 32'h0000_CAFE, 32'h0, 32'h0, 32'h0);
    idle();
    repeat (2) @(negedge clk);
    check("instret_after_reset", instret, 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
MEM/WB pipeline register plus writeback logic for the RISC-V pipelined core. It sits directly upstream of register_set and drives that block's write_en, WriteAdd and Reg_WriteData.
It captures the memory-stage result and aligns and sign-extends load data. It selects the writeback source, suppresses x0 and faulting writes, exports forwarding info to EX, and counts retired instructions.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_valid  in  1  MEM stage holds a real instruction
mem_reg_write  in  1  instruction writes rd
mem_rd  in  REG_ADDR_W  destination register
mem_wb_sel  in  2  source: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM
mem_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
mem_alu_result  in  XLEN  ALU result / load effective address
mem_load_word  in  XLEN  raw aligned word returned by data memory
mem_pc_plus4  in  XLEN  PC+4 of instruction
mem_imm  in  XLEN  U-type immediate (LUI)
wb_stall  in  1  hold WB register contents
wb_flush  in  1  kill instruction entering WB
write_en  out  1  register_set write strobe
WriteAdd  out  REG_ADDR_W  register_set write address
Reg_WriteData  out  XLEN  register_set write data
fwd_valid  out  1  WB holds a committing write (for EX forwarding)
fwd_rd  out  REG_ADDR_W  forwarding destination
fwd_data  out  XLEN  forwarding data (equals Reg_WriteData)
load_misalign  out  1  one-cycle pulse: misaligned or illegal load dropped
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0, asynchronous): WB valid=0, committed=0, write_en=0, WriteAdd=0, Reg_WriteData=0, fwd_*=0, load_misalign=0, instret=0. Deassertion takes effect at the next rising edge.
- Latency: instruction presented at MEM in cycle N is captured at edge N. write_en is high during cycle N+1, and register_set writes at edge N+1.
- Capture at each edge, in priority order:
  - flush first: valid<=0.
  - Else if wb_stall: hold all fields.
  - Else load all mem_* fields and valid<=mem_valid.
- Data select and load alignment happen before the register, so Reg_WriteData is registered.
  - LOAD path: offset = mem_alu_result[1:0].
  - LB/LBU: byte[offset], sign- or zero-extended.
  - LH/LHU: halfword at offset 0 or 2.
  - LW: full word.
- Bad load, when wb_sel=LOAD: LH/LHU at an odd offset, LW at offset≠0, or any other funct3. The captured entry is marked err. Then write_en=0, load_misalign pulses 1 for one cycle, and instret does not increment.
- write_en = valid & reg_write & (rd≠0) & ~err & ~committed. Writes to x0 are never issued, but still retire.
- committed flag:
  - Set at the edge after the first WB cycle while wb_stall=1.
  - Cleared when a new entry loads.
  - A stalled instruction therefore writes and counts exactly once.
- fwd_valid = valid & reg_write & (rd≠0) & ~err. It stays high for the whole stay in WB, including stalled cycles.
- instret increments by 1 on each edge where valid & ~err & ~committed. It wraps modulo 2^CNT_W.
- Simultaneous flush and stall: flush wins. A flush arriving while an uncommitted entry is in WB does not cancel that entry's current-cycle write, which has already been presented.

Decomposition:
- Package riscv_pkg:
  - wb_sel_t enum (WB_ALU, WB_LOAD, WB_PC4, WB_IMM).
  - Load funct3 constants F3_LB/LH/LW/LBU/LHU.
  - XLEN and REG_ADDR_W.
- Sub-module load_align (combinational):
  - Inputs: word, offset, funct3.
  - Outputs: extended data and misalign/illegal flag.

Test Plan:
- ALU writeback: wb_sel=ALU, rd=5, alu=0x0000_1234, valid=1 at edge N. Required: write_en=1, WriteAdd=5, Reg_WriteData=0x1234 in cycle N+1; register_set Data1 reads 0x1234 after edge N+1; instret=1.
- Loads with word=0x80FF_7F01:
  - LB at offset 1 -> 0x0000_007F.
  - LB at offset 3 -> 0xFFFF_FF80.
  - LHU at offset 2 -> 0x0000_80FF.
  - LH at offset 2 -> 0xFFFF_80FF.
- x0 and misaligned writes:
  - rd=0, ALU=0xDEAD -> write_en stays 0, instret +1.
  - LW at addr 0x...02 -> write_en=0, load_misalign pulses 1 cycle, instret unchanged.
- Stall: instruction rd=7 enters WB, wb_stall=1 for 3 cycles. Required: write_en high the first cycle only, fwd_valid high all 4 cycles, instret +1 total.
- Flush/reset:
  - wb_flush=1 with mem_valid=1 -> no write and no count next cycle.
  - flush+stall together -> flush wins.
  - rst_n dropped mid-stream -> all outputs 0 immediately (asynchronously) and instret=0.
- PC+4/IMM: wb_sel=PC4, pc_plus4=0x0000_0104, rd=1 -> Reg_WriteData=0x104; wb_sel=IMM, imm=0xABCD_E000 -> 0xABCD_E000.
